// File: rtl/sr2_operand_stage_if.sv
// Operand-stage bus: request side (register-file read / IR decode) and
// response side (ALU operand B) of the SR2 operand stage.
//   in_valid/in_ready   request handshake, sel/sr2_out/ir_imm request payload
//   out_valid/out_ready operand handshake, operand_out operand payload
//   sel_err, imm_cnt    status back to the controller
// master: the environment driving requests and consuming operands.
// slave : the operand stage itself.
interface sr2_operand_stage_if #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sel;
  logic [WIDTH-1:0] sr2_out;
  logic [IMM_W-1:0] ir_imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] operand_out;
  logic             sel_err;
  logic [CNT_W-1:0] imm_cnt;

  modport master (
    output in_valid, sel, sr2_out, ir_imm, out_ready,
    input  in_ready, out_valid, operand_out, sel_err, imm_cnt
  );

  modport slave (
    input  in_valid, sel, sr2_out, ir_imm, out_ready,
    output in_ready, out_valid, operand_out, sel_err, imm_cnt
  );
endinterface

// File: rtl/sr2_operand_stage.sv
// SR2 operand stage for the LC-3 datapath.
// Selects ALU operand B from SR2, SEXT(imm) or ZEXT(imm) and queues it in a
// 2-entry valid/ready skid buffer. Keeps a sticky illegal-select flag and a
// wrapping count of immediate-mode operands.
// Ports:
//   Clk    system clock, rising edge
//   Reset  synchronous, active-high
//   bus    sr2_operand_stage_if.slave (request in, operand out, status)
//
// state   | meaning
// --------+---------------------------------------------
// S_EMPTY | no operand held, out_valid=0, in_ready=1
// S_ONE   | main register holds head operand
// S_TWO   | main + skid full, in_ready=0
module sr2_operand_stage #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5,
  parameter int CNT_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  sr2_operand_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] imm_cnt_q, imm_cnt_d;

  logic             accept;
  logic             pop;
  logic             is_imm;
  logic [WIDTH-1:0] sext_v;
  logic [WIDTH-1:0] zext_v;
  logic [WIDTH-1:0] value;

  // Fill the whole word with the extension bit first, then overlay the
  // immediate; this also covers IMM_W == WIDTH without a zero-width slice.
  always_comb begin
    sext_v = {WIDTH{bus.ir_imm[IMM_W-1]}};
    sext_v[IMM_W-1:0] = bus.ir_imm;
    zext_v = '0;
    zext_v[IMM_W-1:0] = bus.ir_imm;
    unique case (bus.sel)
      2'b00:   value = bus.sr2_out;
      2'b01:   value = sext_v;
      2'b10:   value = zext_v;
      default: value = '0;
    endcase
  end

  // Handshake outputs depend on state only, so in_ready never combinationally
  // follows out_ready.
  assign bus.in_ready    = (state_q != S_TWO);
  assign bus.out_valid   = (state_q != S_EMPTY);
  assign bus.operand_out = main_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.imm_cnt     = imm_cnt_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;
  assign is_imm = (bus.sel == 2'b01) || (bus.sel == 2'b10);

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    sel_err_d = sel_err_q | (accept & (bus.sel == 2'b11));
    imm_cnt_d = imm_cnt_q + CNT_W'(accept & is_imm);
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          main_d  = value;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          main_d = value;
        end else if (accept) begin
          state_d = S_TWO;
          skid_d  = value;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      sel_err_q <= 1'b0;
      imm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      sel_err_q <= sel_err_d;
      imm_cnt_q <= imm_cnt_d;
    end
  end

endmodule

// File: tb/tb_sr2_operand_stage.sv
module tb_sr2_operand_stage;
  localparam int WIDTH = 16;
  localparam int IMM_W = 5;
  localparam int CNT_W = 8;

  logic Clk;
  logic Reset;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 0;

  sr2_operand_stage_if #(.WIDTH(WIDTH), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();

  sr2_operand_stage #(.WIDTH(WIDTH), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // Reference model: a FIFO of at most two operands, a sticky flag, a counter.
  logic [WIDTH-1:0] mq[$];
  bit               m_err;
  int               m_cnt;

  function automatic logic [WIDTH-1:0] model_value(logic [1:0] s, logic [WIDTH-1:0] r,
                                                   logic [IMM_W-1:0] imm);
    int v;
    case (s)
      2'b00:   v = int'(r);
      2'b01:   v = int'(imm) - ((imm[IMM_W-1]) ? (1 << IMM_W) : 0);
      2'b10:   v = int'(imm);
      default: v = 0;
    endcase
    return v[WIDTH-1:0];
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      mq.delete();
      m_err = 0;
      m_cnt = 0;
    end else begin
      bit acc;
      bit pp;
      logic [WIDTH-1:0] v;
      acc = bus.in_valid && (mq.size() < 2);
      pp  = (mq.size() > 0) && bus.out_ready;
      v   = model_value(bus.sel, bus.sr2_out, bus.ir_imm);
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(v);
        if (bus.sel == 2'b11) m_err = 1;
        if (bus.sel == 2'b01 || bus.sel == 2'b10) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("m_out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("m_in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
      if (mq.size() > 0) chk("m_operand", 32'(bus.operand_out), 32'(mq[0]));
      chk("m_sel_err", 32'(bus.sel_err), 32'(m_err));
      chk("m_imm_cnt", 32'(bus.imm_cnt), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [WIDTH-1:0] r,
                       input logic [IMM_W-1:0] imm, input bit ordy);
    bus.in_valid  = v;
    bus.sel       = s;
    bus.sr2_out   = r;
    bus.ir_imm    = imm;
    bus.out_ready = ordy;
  endtask

  initial begin
    Reset = 1;
    drive(0, 2'b00, '0, '0, 0);
    @(negedge Clk);
    step();
    // 1: reset state
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_operand", 32'(bus.operand_out), 32'h0000);
    chk("rst_sel_err", 32'(bus.sel_err), 0);
    chk("rst_imm_cnt", 32'(bus.imm_cnt), 0);
    Reset = 0;
    cmp_en = 1;

    // 2: operand selection
    drive(1, 2'b01, 16'h0, 5'b10110, 1);
    step();
    chk("sext_operand", 32'(bus.operand_out), 32'hFFF6);
    chk("sext_valid", 32'(bus.out_valid), 1);
    drive(1, 2'b10, 16'h0, 5'b10110, 1);
    step();
    chk("zext_operand", 32'(bus.operand_out), 32'h0016);
    drive(1, 2'b00, 16'h1234, 5'b10110, 1);
    step();
    chk("sr2_operand", 32'(bus.operand_out), 32'h1234);
    drive(0, 2'b00, 16'h0, 5'b0, 1);
    step();
    chk("imm_cnt_two", 32'(bus.imm_cnt), 2);
    chk("drain_valid", 32'(bus.out_valid), 0);

    // 3: backpressure into skid
    drive(1, 2'b00, 16'h0001, 5'b0, 0);
    step();
    drive(1, 2'b00, 16'h0002, 5'b0, 0);
    step();
    chk("full_in_ready", 32'(bus.in_ready), 0);
    drive(1, 2'b00, 16'h0003, 5'b0, 0);
    step();
    step();
    chk("stall_operand_A", 32'(bus.operand_out), 32'h0001);
    bus.out_ready = 1;
    step();
    chk("order_B", 32'(bus.operand_out), 32'h0002);
    step();
    chk("order_C", 32'(bus.operand_out), 32'h0003);
    bus.in_valid = 0;
    step();
    chk("order_drained", 32'(bus.out_valid), 0);

    // 4: streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      drive(1, 2'b00, WIDTH'(i), 5'b0, 1);
      step();
      chk("stream_operand", 32'(bus.operand_out), 32'(i));
      chk("stream_in_ready", 32'(bus.in_ready), 1);
    end
    bus.in_valid = 0;
    step();

    // 5: illegal select
    drive(1, 2'b11, 16'hFFFF, 5'b11111, 1);
    step();
    chk("illegal_operand", 32'(bus.operand_out), 32'h0000);
    chk("illegal_sel_err", 32'(bus.sel_err), 1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 2'b00, WIDTH'(16'h0100 + i), 5'b0, 1);
      step();
      chk("sticky_sel_err", 32'(bus.sel_err), 1);
    end
    bus.in_valid = 0;
    Reset = 1;
    step();
    chk("err_cleared", 32'(bus.sel_err), 0);
    Reset = 0;

    // 6: counter wrap, then reset from TWO
    for (int i = 0; i < 256; i++) begin
      drive(1, 2'b01, 16'h0, 5'(i), 1);
      step();
      if (i == 254) chk("cnt_255", 32'(bus.imm_cnt), 255);
    end
    chk("cnt_wrap", 32'(bus.imm_cnt), 0);
    drive(1, 2'b00, 16'hAAAA, 5'b0, 0);
    step();
    drive(1, 2'b00, 16'hBBBB, 5'b0, 0);
    step();
    chk("two_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 0;
    Reset = 1;
    step();
    chk("rst2_out_valid", 32'(bus.out_valid), 0);
    chk("rst2_in_ready", 32'(bus.in_ready), 1);
    chk("rst2_operand", 32'(bus.operand_out), 32'h0000);
    Reset = 0;
    bus.out_ready = 1;
    step();
    chk("post_rst_valid", 32'(bus.out_valid), 0);
    step();
    chk("post_rst_valid2", 32'(bus.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
